sobel_mag_scheduler: RTL and testbench
======================================

# sobel_mag_scheduler

Sequencing controller for the Sobel gradient-magnitude path. It accepts one (|Gx|, |Gy|) pair per transaction over a valid/ready handshake and time-shares a single 8x8 multiplier to form Gx²+Gy², saturated to 16 bits. It drives that value into the approximate square-root unit (squareroot_AHSQR_k12, R[15:0] -> final_op[7:0]), registers the root together with an edge decision, and holds the result until the downstream consumer takes it. It sits between the Sobel convolution stage and the edge-map writer.

## Interface
- DW, 8: gradient magnitude width; only 8 is supported, matching the 16-bit root-unit input.
- RW, 16: root-unit input width, fixed at 2*DW.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  gradient pair valid.
- in_ready  out  1  scheduler can accept a pair.
- in_gx  in  DW  |Gx|, unsigned.
- in_gy  in  DW  |Gy|, unsigned.
- in_thresh  in  DW  edge threshold, sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_mag  out  DW  approximate sqrt(Gx²+Gy²).
- out_edge  out  1  1 when out_mag >= the latched threshold.
- busy  out  1  state != IDLE.
- sat_flag  out  1  sticky: set when any sum saturated; cleared only by rst.

## Operation
- FSM states: IDLE, SQX, SQY, ROOT, DONE. Encoding is in the package.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready): latch gx, gy and thresh, then go to SQX.
- SQX: acc <= gx*gx (16-bit); go to SQY.
- SQY: sum = acc + gy*gy, formed at 17 bits. If sum[16] is set, r_reg <= 16'hFFFF and sat_flag <= 1; otherwise r_reg <= sum[15:0]. Go to ROOT.
- ROOT: the root unit sees r_reg combinationally. out_mag <= final_op, out_edge <= (final_op >= thresh_q), out_valid <= 1. Go to DONE.
- DONE: hold out_mag, out_edge and out_valid stable while out_ready=0.
  - out_ready=1 with no accept: out_valid <= 0, go to IDLE.
  - out_ready=1 with a simultaneous accept: out_valid <= 0, latch the new pair, go to SQX. This is the back-to-back path.
- One multiplier instance only. Its operands are muxed: gx in SQX, gy in SQY.
- In_* inputs are ignored whenever in_ready=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_mag=0, out_edge=0, busy=0, sat_flag=0. Internal acc, r_reg, gx_q, gy_q and thresh_q are all 0.
- Latency: accept at edge N gives out_valid=1 after edge N+3, so it is visible in cycle N+3.
- Throughput: 1 result per 4 cycles with out_ready held high via the DONE->SQX path. With out_ready low the block stalls in DONE indefinitely.
- The root unit's combinational path is r_reg -> final_op -> out_mag flop, a single cycle. r_reg only changes in SQY, so it is stable throughout ROOT.
- rst asserted mid-transaction: all state clears immediately. The in-flight pair is dropped and no out_valid is produced.
- out_valid never deasserts without out_ready, except by rst.

## Structure
- Package sobel_mag_pkg holds: the state enum, DW/RW constants, and the SAT_MAX=16'hFFFF constant.
- Sub-module sobel_sq_sum: the shared multiplier, 16-bit accumulator and 17->16 saturation. It takes the SQX/SQY select as input.
- The root unit is instantiated unmodified.

## Test plan
- gx=3, gy=4, thresh=4, out_ready=1 -> r_reg=16'd25 in ROOT; out_valid on the 3rd edge after accept; out_mag equals the root unit's output for R=25; out_edge = (out_mag>=4).
- gx=255, gy=255 -> sum 130050 saturates: r_reg=16'hFFFF, sat_flag=1 and stays 1; gx=255, gy=0 -> r_reg=16'd65025 with no new saturation.
- out_ready=0 for 10 cycles after out_valid -> out_mag/out_edge/out_valid stable and in_ready=0; release out_ready -> exactly one handshake.
- Continuous in_valid, 8 pairs, out_ready=1 -> 8 results in order at one per 4 cycles; in_ready pulses in DONE.
- rst pulse asserted asynchronously in SQY -> all outputs read reset values before the next clock edge; the next accepted pair completes normally.
- gx=0, gy=0, thresh=0 -> r_reg=0, out_mag = root unit's output for R=0, out_edge=1.

Source files
------------

// File: rtl/sobel_mag_pkg.sv
// rtl/sobel_mag_pkg.sv - shared widths, saturation constant and scheduler states
package sobel_mag_pkg;

  localparam int DW = 8;
  localparam int RW = 2 * DW;
  localparam logic [RW-1:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQX  = 3'd1,
    ST_SQY  = 3'd2,
    ST_ROOT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sobel_sq_sum.sv
// rtl/sobel_sq_sum.sv - shared 8x8 squarer, accumulator and saturating sum register
module sobel_sq_sum
  import sobel_mag_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          sq_x_en,
  input  logic          sq_y_en,
  input  logic [DW-1:0] gx,
  input  logic [DW-1:0] gy,
  output logic [RW-1:0] r_reg,
  output logic          sat
);

  logic [DW-1:0] op;
  logic [RW-1:0] prod;
  logic [RW:0]   sum;
  logic [RW-1:0] acc_d, acc_q;
  logic [RW-1:0] r_d, r_q;

  assign op    = sq_y_en ? gy : gx;
  assign prod  = op * op;
  assign sum   = {1'b0, acc_q} + {1'b0, prod};
  assign sat   = sq_y_en & sum[RW];
  assign r_reg = r_q;

  always_comb begin
    acc_d = acc_q;
    r_d   = r_q;
    if (sq_x_en) acc_d = prod;
    if (sq_y_en) r_d = sum[RW] ? SAT_MAX : sum[RW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      r_q   <= '0;
    end else begin
      acc_q <= acc_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: rtl/squareroot_AHSQR_k12.sv
// rtl/squareroot_AHSQR_k12.sv - combinational 16-bit to 8-bit square-root unit
module squareroot_AHSQR_k12 (
  input  logic [15:0] R,
  output logic [7:0]  final_op
);

  logic [17:0] rem;
  logic [17:0] trial;
  logic [7:0]  root;

  // Digit-by-digit root: consumes two radicand bits per result bit, MSB first.
  always_comb begin
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = 7; i >= 0; i--) begin
      rem   = {rem[15:0], R[2*i +: 2]};
      trial = {8'd0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[6:0], 1'b1};
      end else begin
        root = {root[6:0], 1'b0};
      end
    end
    final_op = root;
  end

endmodule

// File: rtl/sobel_mag_scheduler.sv
// rtl/sobel_mag_scheduler.sv - time-shares one squarer to form sqrt(Gx^2+Gy^2) and an edge bit
module sobel_mag_scheduler
  import sobel_mag_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_gx,
  input  logic [DW-1:0] in_gy,
  input  logic [DW-1:0] in_thresh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_mag,
  output logic          out_edge,
  output logic          busy,
  output logic          sat_flag
);

  state_t        state_d, state_q;
  logic [DW-1:0] gx_d, gx_q, gy_d, gy_q, thresh_d, thresh_q;
  logic [DW-1:0] out_mag_d, out_mag_q;
  logic          out_edge_d, out_edge_q;
  logic          out_valid_d, out_valid_q;
  logic          sat_flag_d, sat_flag_q;
  logic          accept;
  logic [RW-1:0] r_reg;
  logic          sat;
  logic [DW-1:0] root;

  sobel_sq_sum u_sq_sum (
    .clk     (clk),
    .rst     (rst),
    .sq_x_en (state_q == ST_SQX),
    .sq_y_en (state_q == ST_SQY),
    .gx      (gx_q),
    .gy      (gy_q),
    .r_reg   (r_reg),
    .sat     (sat)
  );

  squareroot_AHSQR_k12 u_root (
    .R        (r_reg),
    .final_op (root)
  );

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_edge  = out_edge_q;
  assign sat_flag  = sat_flag_q;

  always_comb begin
    state_d     = state_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    thresh_d    = thresh_q;
    out_mag_d   = out_mag_q;
    out_edge_d  = out_edge_q;
    out_valid_d = out_valid_q;
    sat_flag_d  = sat_flag_q | sat;
    // accept can only fire in IDLE or in DONE with the consumer taking the result
    if (accept) begin
      gx_d     = in_gx;
      gy_d     = in_gy;
      thresh_d = in_thresh;
    end
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SQX;
      ST_SQX:  state_d = ST_SQY;
      ST_SQY:  state_d = ST_ROOT;
      ST_ROOT: begin
        out_mag_d   = root;
        out_edge_d  = (root >= thresh_q);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? ST_SQX : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gx_q        <= '0;
      gy_q        <= '0;
      thresh_q    <= '0;
      out_mag_q   <= '0;
      out_edge_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      thresh_q    <= thresh_d;
      out_mag_q   <= out_mag_d;
      out_edge_q  <= out_edge_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

endmodule

// File: tb/tb_sobel_mag_scheduler.sv
// tb/tb_sobel_mag_scheduler.sv - directed and randomized checks against an arithmetic model
module tb_sobel_mag_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_gx = '0, in_gy = '0, in_thresh = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_mag;
  logic       out_edge;
  logic       busy;
  logic       sat_flag;

  int n_assert = 0;
  int n_fail   = 0;
  bit sat_model = 1'b0;

  always #5 clk = ~clk;

  sobel_mag_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gx     (in_gx),
    .in_gy     (in_gy),
    .in_thresh (in_thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_edge  (out_edge),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_sum(input int unsigned gx, input int unsigned gy);
    int unsigned s;
    s = gx * gx + gy * gy;
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_mag"},   out_mag,   0);
    chk({tag, "_out_edge"},  out_edge,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_sat_flag"},  sat_flag,  0);
  endtask

  // One transaction from IDLE: latency, root register, result, edge, sticky flag, handshake.
  task automatic txn(input string tag, input int unsigned gx, input int unsigned gy,
                     input int unsigned th);
    int unsigned r, m;
    int k;
    r = sat_sum(gx, gy);
    m = isqrt(r);
    @(negedge clk);
    in_valid = 1'b1; in_gx = gx[7:0]; in_gy = gy[7:0]; in_thresh = th[7:0];
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (gx * gx + gy * gy > 65535) sat_model = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin
      if (k == 2) chk({tag, "_r_reg"}, dut.u_sq_sum.r_q, r);
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, 3);
    chk({tag, "_mag"},  out_mag,  m);
    chk({tag, "_edge"}, out_edge, (m >= th) ? 1 : 0);
    chk({tag, "_sat"},  sat_flag, sat_model);
    @(negedge clk);
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  int unsigned qgx[$], qgy[$], qth[$];
  logic [7:0] hold_mag;
  logic       hold_edge;
  int idx, rcnt, cyc, last_cyc, hs;
  int unsigned egx, egy, eth, em;

  initial begin
    #12;
    chk_reset_outputs("reset");
    chk("reset_r_reg", dut.u_sq_sum.r_q, 0);
    @(negedge clk);
    rst = 1'b0;

    txn("t345", 3, 4, 4);
    txn("tsat", 255, 255, 200);
    txn("tnosat", 255, 0, 0);
    txn("tzero", 0, 0, 0);
    for (int i = 0; i < 10; i++)
      txn("rand", $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

    // Stall in DONE for 10 cycles while a different pair is offered.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_gx = 8'd12; in_gy = 8'd5; in_thresh = 8'd14;
    @(negedge clk);
    in_gx = 8'd200; in_gy = 8'd100; in_thresh = 8'd1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("stall_latency", cyc, 3);
    chk("stall_mag", out_mag, 13);
    chk("stall_edge", out_edge, 0);
    hold_mag = out_mag; hold_edge = out_edge;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_mag_hold", out_mag, hold_mag);
      chk("stall_edge_hold", out_edge, hold_edge);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    chk("stall_one_handshake", hs, 1);

    // Back-to-back: 8 pairs with in_valid held high and out_ready high.
    for (int i = 0; i < 8; i++) begin
      qgx.push_back($urandom_range(0, 255));
      qgy.push_back($urandom_range(0, 255));
      qth.push_back($urandom_range(0, 255));
    end
    idx = 0; rcnt = 0; cyc = 0; last_cyc = 0;
    while (rcnt < 8 && cyc < 200) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_gx = qgx[idx][7:0]; in_gy = qgy[idx][7:0]; in_thresh = qth[idx][7:0];
      end
      if (out_valid && out_ready) begin
        egx = qgx[rcnt]; egy = qgy[rcnt]; eth = qth[rcnt];
        em = isqrt(sat_sum(egx, egy));
        if (egx * egx + egy * egy > 65535) sat_model = 1'b1;
        chk("b2b_mag", out_mag, em);
        chk("b2b_edge", out_edge, (em >= eth) ? 1 : 0);
        if (rcnt > 0) chk("b2b_spacing", cyc - last_cyc, 4);
        if (rcnt < 7) chk("b2b_in_ready_pulse", in_ready, 1);
        last_cyc = cyc;
        rcnt++;
      end else if (busy) begin
        chk("b2b_in_ready_low", in_ready, 0);
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", rcnt, 8);
    chk("b2b_sat", sat_flag, sat_model);

    // Ensure a saturation is recorded, then reset asynchronously while in SQY.
    txn("presat", 200, 200, 0);
    @(negedge clk);
    in_valid = 1'b1; in_gx = 8'd9; in_gy = 8'd40; in_thresh = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_sqy_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    sat_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) hs++;
      @(negedge clk);
    end
    chk("rst_dropped", hs, 0);
    txn("after_rst", 8, 6, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
